instr_stream_loader: RTL and testbench

Receiver end of the byte-serial instruction load interface. It sits inside CPU, between the instr_i pin and instruction memory. Waits for a start byte, then packs incoming bytes MSB-first into 32-bit instruction words and issues one instruction-memory write per word. Stops on a terminator word, or when memory is full.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/instr_stream_loader_assembler.sv | 34 +++
 rtl/instr_stream_loader.sv | 94 +++++++++
 tb/tb_instr_stream_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the byte-serial instruction loader.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [7:0]        DEF_START_BYTE = 8'hFE;
    localparam logic [WORD_W-1:0] DEF_END_WORD   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/instr_stream_loader_assembler.sv
// Packs bytes MSB-first into 32-bit words; word_valid flags the edge that samples the fourth byte.
module instr_word_assembler
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-1:0] shift_p0;
    logic [1:0]        idx_p0;

    // The word is presented combinationally so the loader can act on the same edge that samples byte 3.
    assign word_valid = shift_en && (idx_p0 == 2'd3);
    assign word       = {shift_p0[WORD_W-9:0], byte_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_p0 <= '0;
            idx_p0   <= 2'd0;
        end else if (clear) begin
            shift_p0 <= '0;
            idx_p0   <= 2'd0;
        end else if (shift_en) begin
            shift_p0 <= word;
            idx_p0   <= idx_p0 + 2'd1;
        end
    end

endmodule

// File: rtl/instr_stream_loader.sv
// Receives the byte-serial instruction stream and issues one instruction-memory write per word.
module instr_stream_loader
    import cpu_pkg::*;
#(
    parameter int                DEPTH      = 64,
    parameter int                ADDR_W     = 6,
    parameter logic [7:0]        START_BYTE = DEF_START_BYTE,
    parameter logic [WORD_W-1:0] END_WORD   = DEF_END_WORD
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic [7:0]        instr_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WORD_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    loader_state_t     state;
    logic [ADDR_W:0]   ptr;
    logic              start_seen;
    logic              shift_en;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign start_seen   = (state == IDLE) && (instr_i == START_BYTE);
    assign shift_en     = (state == LOAD);
    assign word_count_o = ptr;

    instr_word_assembler u_assembler (
        .clk        (clk_i),
        .reset      (reset),
        .clear      (start_seen),
        .shift_en   (shift_en),
        .byte_in    (instr_i),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            busy_o      <= 1'b0;
            load_done_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            wr_en_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_seen) begin
                        state  <= LOAD;
                        busy_o <= 1'b1;
                    end
                end
                LOAD: begin
                    if (word_valid) begin
                        if (word == END_WORD) begin
                            state       <= DONE;
                            busy_o      <= 1'b0;
                            load_done_o <= 1'b1;
                        end else if (ptr < DEPTH_W) begin
                            wr_en_o   <= 1'b1;
                            wr_addr_o <= ptr[ADDR_W-1:0];
                            wr_data_o <= word;
                            ptr       <= ptr + 1'b1;
                        end else begin
                            // Memory full: drop the word and end the session.
                            state       <= DONE;
                            busy_o      <= 1'b0;
                            load_done_o <= 1'b1;
                            overflow_o  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader: a DEPTH=64 instance and a DEPTH=4 instance share the stimulus.
module tb_instr_stream_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  instr;

    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        load_done;
    logic        overflow;
    logic [6:0]  word_count;

    logic        wr_en4;
    logic [1:0]  wr_addr4;
    logic [31:0] wr_data4;
    logic        busy4;
    logic        load_done4;
    logic        overflow4;
    logic [2:0]  word_count4;

    int checks;
    int errors;

    int          n_str;
    logic [5:0]  log_addr [0:15];
    logic [31:0] log_data [0:15];
    int          n_str4;
    logic [1:0]  log_addr4 [0:15];
    logic [31:0] log_data4 [0:15];

    instr_stream_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk_i        (clk),
        .reset        (reset),
        .instr_i      (instr),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .busy_o       (busy),
        .load_done_o  (load_done),
        .overflow_o   (overflow),
        .word_count_o (word_count)
    );

    instr_stream_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
        .clk_i        (clk),
        .reset        (reset),
        .instr_i      (instr),
        .wr_en_o      (wr_en4),
        .wr_addr_o    (wr_addr4),
        .wr_data_o    (wr_data4),
        .busy_o       (busy4),
        .load_done_o  (load_done4),
        .overflow_o   (overflow4),
        .word_count_o (word_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each call leaves time at 1 unit after the edge that sampled b.
    task automatic drive(input logic [7:0] b);
        instr = b;
        @(posedge clk);
        #1;
        if (wr_en) begin
            if (n_str < 16) begin
                log_addr[n_str] = wr_addr;
                log_data[n_str] = wr_data;
            end
            n_str++;
        end
        if (wr_en4) begin
            if (n_str4 < 16) begin
                log_addr4[n_str4] = wr_addr4;
                log_data4[n_str4] = wr_data4;
            end
            n_str4++;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        drive(w[31:24]);
        drive(w[23:16]);
        drive(w[15:8]);
        drive(w[7:0]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr = 8'h00;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        n_str  = 0;
        n_str4 = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr = 8'hFE;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, load_done, overflow, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%0b addr=%0d data=%h busy=%0b done=%0b ovf=%0b cnt=%0d want all 0",
                     wr_en, wr_addr, wr_data, busy, load_done, overflow, word_count);
        end
        reset  = 1'b0;
        n_str  = 0;
        n_str4 = 0;
    endtask

    task automatic test_first_word();
        do_reset();
        drive(8'h00);
        drive(8'h00);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %0b want 0", busy);
        end
        drive(8'hFE);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy got %0b want 1", busy);
        end
        drive(8'h00);
        drive(8'hA0);
        drive(8'h01);
        checks++;
        if (n_str !== 0) begin
            errors++;
            $display("FAIL early_strobe got %0d strobes want 0", n_str);
        end
        drive(8'h13);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'h00A00113 || word_count !== 7'd1) begin
            errors++;
            $display("FAIL first_word got en=%0b addr=%0d data=%h cnt=%0d want en=1 addr=0 data=00a00113 cnt=1",
                     wr_en, wr_addr, wr_data, word_count);
        end
        drive(8'h00);
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 32'h00A00113) begin
            errors++;
            $display("FAIL strobe_hold got en=%0b addr=%0d data=%h want en=0 addr=0 data=00a00113",
                     wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_terminator();
        logic [31:0] words [0:2];
        words[0] = 32'h00500093;
        words[1] = 32'h00100113;
        words[2] = 32'h002081B3;
        do_reset();
        drive(8'hFE);
        for (int i = 0; i < 3; i++) send_word(words[i]);
        drive(8'hFF);
        drive(8'hFF);
        drive(8'hFF);
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL done_early got %0b want 0", load_done);
        end
        drive(8'hFF);
        checks++;
        if (load_done !== 1'b1 || busy !== 1'b0 || word_count !== 7'd3) begin
            errors++;
            $display("FAIL term_state got done=%0b busy=%0b cnt=%0d want done=1 busy=0 cnt=3",
                     load_done, busy, word_count);
        end
        checks++;
        if (n_str !== 3) begin
            errors++;
            $display("FAIL term_strobes got %0d want 3", n_str);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_addr[i] !== 6'(i) || log_data[i] !== words[i]) begin
                    errors++;
                    $display("FAIL term_write%0d got addr=%0d data=%h want addr=%0d data=%h",
                             i, log_addr[i], log_data[i], i, words[i]);
                end
            end
        end
    endtask

    task automatic test_done_ignores();
        drive(8'hFE);
        drive(8'h01);
        drive(8'h02);
        drive(8'h03);
        drive(8'h04);
        drive(8'h00);
        checks++;
        if (n_str !== 3 || load_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_ignore got strobes=%0d done=%0b busy=%0b want strobes=3 done=1 busy=0",
                     n_str, load_done, busy);
        end
        do_reset();
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL done_cleared got %0b want 0", load_done);
        end
    endtask

    task automatic test_data_bytes();
        do_reset();
        drive(8'hFE);
        send_word(32'hFF123456);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'hFF123456 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ff_data got en=%0b addr=%0d data=%h busy=%0b want en=1 addr=0 data=ff123456 busy=1",
                     wr_en, wr_addr, wr_data, busy);
        end
        send_word(32'hFEFFFFFF);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd1 || wr_data !== 32'hFEFFFFFF || busy !== 1'b1 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL fe_data got en=%0b addr=%0d data=%h busy=%0b done=%0b want en=1 addr=1 data=feffffff busy=1 done=0",
                     wr_en, wr_addr, wr_data, busy, load_done);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(8'hFE);
        for (int i = 1; i <= 5; i++) send_word({4{8'(i * 8'h11)}});
        drive(8'h00);
        checks++;
        if (n_str4 !== 4 || overflow4 !== 1'b1 || load_done4 !== 1'b1 || word_count4 !== 3'd4 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL overflow_state got strobes=%0d ovf=%0b done=%0b cnt=%0d busy=%0b want strobes=4 ovf=1 done=1 cnt=4 busy=0",
                     n_str4, overflow4, load_done4, word_count4, busy4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_addr4[i] !== 2'(i) || log_data4[i] !== {4{8'((i + 1) * 8'h11)}}) begin
                    errors++;
                    $display("FAIL overflow_write%0d got addr=%0d data=%h want addr=%0d data=%h",
                             i, log_addr4[i], log_data4[i], i, {4{8'((i + 1) * 8'h11)}});
                end
            end
        end
        checks++;
        if (overflow !== 1'b0 || word_count !== 7'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL deep_no_overflow got ovf=%0b cnt=%0d busy=%0b want ovf=0 cnt=5 busy=1",
                     overflow, word_count, busy);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        drive(8'hFE);
        drive(8'h11);
        drive(8'h22);
        do_reset();
        checks++;
        if ({wr_en, wr_addr, wr_data, busy, load_done, overflow, word_count} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got en=%0b addr=%0d data=%h busy=%0b cnt=%0d want all 0",
                     wr_en, wr_addr, wr_data, busy, word_count);
        end
        drive(8'hFE);
        drive(8'hAA);
        drive(8'hBB);
        drive(8'hCC);
        checks++;
        if (n_str !== 0) begin
            errors++;
            $display("FAIL midreset_strobe got %0d strobes want 0", n_str);
        end
        drive(8'hDD);
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_data !== 32'hAABBCCDD || word_count !== 7'd1) begin
            errors++;
            $display("FAIL midreset_word got en=%0b addr=%0d data=%h cnt=%0d want en=1 addr=0 data=aabbccdd cnt=1",
                     wr_en, wr_addr, wr_data, word_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_str  = 0;
        n_str4 = 0;
        reset  = 1'b1;
        instr  = 8'h00;
        test_reset();
        test_first_word();
        test_terminator();
        test_done_ignores();
        test_data_bytes();
        test_overflow();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
